// File: rtl/serial_operand_shifter.sv
// serial_operand_shifter
// Accepts a WIDTH-bit operand pair on a valid/ready handshake and streams it
// LSB-first, one bit pair per clock, on X/Y. FIRST/LAST flag the word edges so
// the downstream serial adder can clear its carry. A new word can be loaded on
// the LAST edge of the current one, so back-to-back words run with no bubble.
module serial_operand_shifter #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] A_IN,
   input  logic [WIDTH-1:0] B_IN,
   output logic             X,
   output logic             Y,
   output logic             BIT_VALID,
   output logic             FIRST,
   output logic             LAST,
   output logic             BUSY
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic shifting;
   logic at_last;
   logic accept;

   // Handshake: ready when idle or on the final bit of a word; held low in reset
   always_comb begin
      shifting = (state_q == S_SHIFT);
      at_last  = shifting && (cnt_q == CNT_LAST);
      IN_READY = RESET && ((state_q == S_IDLE) || at_last);
      accept   = IN_VALID && IN_READY;
   end

   // Next-state logic: load on accept, shift otherwise, drop to idle after LAST
   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               sa_d    = A_IN;
               sb_d    = B_IN;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (!at_last) begin
               sa_d  = sa_q >> 1;
               sb_d  = sb_q >> 1;
               cnt_d = cnt_q + CNT_W'(1);
            end else if (accept) begin
               sa_d  = A_IN;
               sb_d  = B_IN;
               cnt_d = '0;
            end else begin
               sa_d    = '0;
               sb_d    = '0;
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: begin
            sa_d    = '0;
            sb_d    = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State register; reset abandons any word in flight immediately
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= S_IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         cnt_q   <= cnt_d;
      end
   end

   // Serial outputs are decoded from registered state only
   always_comb begin
      BIT_VALID = shifting;
      BUSY      = shifting;
      X         = shifting && sa_q[0];
      Y         = shifting && sb_q[0];
      FIRST     = shifting && (cnt_q == '0);
      LAST      = at_last;
   end

endmodule

// File: tb/tb_serial_operand_shifter.sv
// Bench for serial_operand_shifter: a WIDTH=4 and a WIDTH=1 instance share a
// clock. Drivers push expected bit pairs into per-instance queues after each
// accept edge; monitors on the falling edge pop and compare.
module tb_serial_operand_shifter;

   typedef struct packed {
      logic x;
      logic y;
      logic first;
      logic last;
   } bit_t;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // WIDTH=4 instance signals
   logic       rst4, vld4, rdy4, x4, y4, bv4, f4, l4, busy4;
   logic [3:0] a4, b4;
   // WIDTH=1 instance signals
   logic       rst1, vld1, rdy1, x1, y1, bv1, f1, l1, busy1;
   logic [0:0] a1, b1;

   bit_t q4[$];
   bit_t q1[$];

   int n_vec  = 0;
   int n_fail = 0;

   serial_operand_shifter #(.WIDTH(4)) u_w4 (
      .CLK(clk), .RESET(rst4), .IN_VALID(vld4), .IN_READY(rdy4),
      .A_IN(a4), .B_IN(b4), .X(x4), .Y(y4), .BIT_VALID(bv4),
      .FIRST(f4), .LAST(l4), .BUSY(busy4)
   );

   serial_operand_shifter #(.WIDTH(1)) u_w1 (
      .CLK(clk), .RESET(rst1), .IN_VALID(vld1), .IN_READY(rdy1),
      .A_IN(a1), .B_IN(b1), .X(x1), .Y(y1), .BIT_VALID(bv1),
      .FIRST(f1), .LAST(l1), .BUSY(busy1)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor for the WIDTH=4 instance
   always @(negedge clk) begin
      bit_t e;
      if (!rst4) begin
         chk("w4 reset outs", {2'b0, x4, y4, bv4, f4, l4, busy4}, 8'h00);
         chk("w4 reset ready", {7'b0, rdy4}, 8'h00);
      end else if (bv4) begin
         if (q4.size() == 0) begin
            chk("w4 unexpected bit", {7'b0, bv4}, 8'h00);
         end else begin
            e = q4.pop_front();
            chk("w4 x/y/first/last", {4'b0, x4, y4, f4, l4}, {4'b0, e.x, e.y, e.first, e.last});
            chk("w4 busy", {7'b0, busy4}, 8'h01);
            chk("w4 ready", {7'b0, rdy4}, {7'b0, e.last});
         end
      end else begin
         chk("w4 idle outs", {2'b0, x4, y4, bv4, f4, l4, busy4}, 8'h00);
         chk("w4 idle ready", {7'b0, rdy4}, 8'h01);
         chk("w4 missing bit", 8'(q4.size()), 8'h00);
      end
   end

   // Monitor for the WIDTH=1 instance
   always @(negedge clk) begin
      bit_t e;
      if (!rst1) begin
         chk("w1 reset outs", {2'b0, x1, y1, bv1, f1, l1, busy1}, 8'h00);
         chk("w1 reset ready", {7'b0, rdy1}, 8'h00);
      end else if (bv1) begin
         if (q1.size() == 0) begin
            chk("w1 unexpected bit", {7'b0, bv1}, 8'h00);
         end else begin
            e = q1.pop_front();
            chk("w1 x/y/first/last", {4'b0, x1, y1, f1, l1}, {4'b0, e.x, e.y, e.first, e.last});
            chk("w1 ready", {7'b0, rdy1}, 8'h01);
         end
      end else begin
         chk("w1 idle outs", {2'b0, x1, y1, bv1, f1, l1, busy1}, 8'h00);
         chk("w1 idle ready", {7'b0, rdy1}, 8'h01);
         chk("w1 missing bit", 8'(q1.size()), 8'h00);
      end
   end

   // ex/ey list the expected serial bits in cycle order, cycle 1 in bit 3
   task automatic send4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] ex, input logic [3:0] ey);
      bit_t e;
      bit   done = 1'b0;
      @(negedge clk);
      vld4 = 1'b1;
      a4   = a;
      b4   = b;
      for (int i = 0; i < 50 && !done; i++) begin
         if (rdy4) begin
            @(posedge clk);
            for (int k = 0; k < 4; k++) begin
               e.x     = ex[3-k];
               e.y     = ey[3-k];
               e.first = (k == 0);
               e.last  = (k == 3);
               q4.push_back(e);
            end
            done = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      if (!done) chk("w4 accept timeout", 8'h00, 8'h01);
   endtask

   task automatic send1(input logic a, input logic b, input logic ex, input logic ey);
      bit_t e;
      bit   done = 1'b0;
      @(negedge clk);
      vld1 = 1'b1;
      a1   = a;
      b1   = b;
      for (int i = 0; i < 50 && !done; i++) begin
         if (rdy1) begin
            @(posedge clk);
            e.x     = ex;
            e.y     = ey;
            e.first = 1'b1;
            e.last  = 1'b1;
            q1.push_back(e);
            done = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      if (!done) chk("w1 accept timeout", 8'h00, 8'h01);
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && (q4.size() != 0 || q1.size() != 0); i++) @(negedge clk);
      chk("drain queues empty", 8'(q4.size() + q1.size()), 8'h00);
   endtask

   initial begin
      rst4 = 1'b0; vld4 = 1'b0; a4 = '0; b4 = '0;
      rst1 = 1'b0; vld1 = 1'b0; a1 = '0; b1 = '0;
      repeat (2) @(posedge clk);
      #2;
      rst4 = 1'b1;
      rst1 = 1'b1;

      // Single word: X=1,1,0,1  Y=0,1,1,0
      send4(4'b1011, 4'b0110, 4'b1101, 4'b0110);
      @(negedge clk) vld4 = 1'b0;
      drain();
      repeat (2) @(negedge clk);

      // Back-to-back: X=1,1,0,0,0,0,1,1  Y=1,0,0,0,1,1,1,1
      send4(4'h3, 4'h1, 4'b1100, 4'b1000);
      send4(4'hC, 4'hF, 4'b0011, 4'b1111);
      @(negedge clk) vld4 = 1'b0;
      drain();
      repeat (2) @(negedge clk);

      // A_IN changes mid-word: first word stays 1,0,1,0, second accepted at LAST
      send4(4'h5, 4'h0, 4'b1010, 4'b0000);
      send4(4'hA, 4'h0, 4'b0101, 4'b0000);
      @(negedge clk) vld4 = 1'b0;
      drain();
      repeat (2) @(negedge clk);

      // Reset during bit 2 of A=F
      send4(4'hF, 4'h0, 4'b1111, 4'b0000);
      @(negedge clk) vld4 = 1'b0;
      @(posedge clk);
      #2;
      chk("pre-reset bit valid", {6'b0, x4, bv4}, 8'h03);
      q4.delete();
      rst4 = 1'b0;
      #1;
      chk("async reset drop", {5'b0, x4, bv4, busy4}, 8'h00);
      chk("async reset ready", {7'b0, rdy4}, 8'h00);
      @(posedge clk);
      #2;
      rst4 = 1'b1;
      #1;
      chk("post-reset ready", {7'b0, rdy4}, 8'h01);
      send4(4'h8, 4'h0, 4'b0001, 4'b0000);
      @(negedge clk) vld4 = 1'b0;
      drain();

      // Idle stability
      repeat (20) @(negedge clk);

      // WIDTH=1 streaming: X=1,0,1  Y=1,1,0
      send1(1'b1, 1'b1, 1'b1, 1'b1);
      send1(1'b0, 1'b1, 1'b0, 1'b1);
      send1(1'b1, 1'b0, 1'b1, 1'b0);
      @(negedge clk) vld1 = 1'b0;
      drain();
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL global timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

endmodule
